// File: rtl/lock_entry_ctrl.sv
// Buffers entered digits and replays them to the lock core, one o_CE pulse per digit with
// GAP_CYCLES idle between pulses; tracks failures and lockout. Optional macro: LOCK_ENTRY_CTRL_TIMEOUT_EN.
module lock_entry_ctrl #(
    parameter int DEPTH          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int SETTLE_CYCLES  = 2,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       i_Rst,
    input  logic       i_digit_valid,
    input  logic [3:0] iv_digit,
    input  logic       i_submit,
    input  logic       i_program,
    input  logic       i_relock,
    input  logic [7:0] iv_ack,
    output logic       o_CE,
    output logic       o_set_data,
    output logic [3:0] ov_data,
    output logic       o_busy,
    output logic       o_unlocked,
    output logic       o_locked_out,
    output logic       o_overflow,
    output logic [2:0] ov_fail_cnt
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int TW = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_GAP, S_SETTLE, S_CHECK, S_UNLOCKED, S_LOCKOUT
    } state_t;

    state_t         state_q, state_d;
    logic           mode_prog_q, mode_prog_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [2:0]     fail_q, fail_d;
    logic           ovf_q, ovf_d;
    logic [3:0]     dbuf_q [DEPTH];
    logic           wr_en;
    logic           cap_en;
    logic           push_ok;
    logic           entry_st;
    logic           tmo_fire;
    logic           unused_ack;

    assign unused_ack = ^iv_ack[6:0];
    assign entry_st   = (state_q == S_IDLE) || (state_q == S_UNLOCKED);
    assign push_ok    = i_digit_valid && (cnt_q < CW'(DEPTH));

`ifdef LOCK_ENTRY_CTRL_TIMEOUT_EN
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    logic [OW-1:0] tmo_q;

    assign tmo_fire = entry_st && (cnt_q != '0) && (tmo_q == OW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (i_Rst) begin
            tmo_q <= '0;
        end else if (entry_st && (cnt_q != '0) && !push_ok && !tmo_fire) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mode_prog_d = mode_prog_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        fail_d      = fail_q;
        ovf_d       = ovf_q;
        wr_en       = 1'b0;
        cap_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // An accepted submit swallows a digit strobed in the same cycle.
                if (i_submit && (cnt_q != '0)) begin
                    state_d     = S_SEND;
                    mode_prog_d = 1'b0;
                    idx_d       = '0;
                    ovf_d       = 1'b0;
                end else begin
                    cap_en = 1'b1;
                end
            end
            S_UNLOCKED: begin
                if (i_relock) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (i_program && (cnt_q != '0)) begin
                    state_d     = S_SEND;
                    mode_prog_d = 1'b1;
                    idx_d       = '0;
                    ovf_d       = 1'b0;
                end else begin
                    cap_en = 1'b1;
                end
            end
            S_SEND: begin
                state_d = S_GAP;
                tmr_d   = '0;
            end
            S_GAP: begin
                if (tmr_q == TW'(GAP_CYCLES - 1)) begin
                    if ((CW'(idx_q) + CW'(1)) < cnt_q) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SEND;
                    end else if (mode_prog_q) begin
                        state_d     = S_IDLE;
                        mode_prog_d = 1'b0;
                        cnt_d       = '0;
                        fail_d      = '0;
                    end else begin
                        state_d = S_SETTLE;
                        tmr_d   = '0;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr_q == TW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_CHECK;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                if (iv_ack[7]) begin
                    state_d = S_UNLOCKED;
                    fail_d  = '0;
                end else if (({1'b0, fail_q} + 4'd1) >= 4'(MAX_FAIL)) begin
                    state_d = S_LOCKOUT;
                    fail_d  = 3'(MAX_FAIL);
                    tmr_d   = '0;
                end else begin
                    state_d = S_IDLE;
                    fail_d  = fail_q + 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (tmr_q == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                    cnt_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cap_en) begin
            if (push_ok) begin
                wr_en = 1'b1;
                cnt_d = cnt_q + 1'b1;
            end else begin
                if (i_digit_valid) ovf_d = 1'b1;
                if (tmo_fire) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_Rst) begin
            state_q     <= S_IDLE;
            mode_prog_q <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            fail_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prog_q <= mode_prog_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            fail_q      <= fail_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) dbuf_q[IW'(cnt_q)] <= iv_digit;
    end

    always_comb begin
        o_CE         = (state_q == S_SEND);
        o_busy       = (state_q == S_SEND) || (state_q == S_GAP) ||
                       (state_q == S_SETTLE) || (state_q == S_CHECK);
        o_set_data   = 1'b0;
        ov_data      = 4'd0;
        if ((state_q == S_SEND) || (state_q == S_GAP)) begin
            o_set_data = mode_prog_q;
            ov_data    = dbuf_q[idx_q];
        end
        o_unlocked   = (state_q == S_UNLOCKED);
        o_locked_out = (state_q == S_LOCKOUT);
        o_overflow   = ovf_q;
        ov_fail_cnt  = fail_q;
    end
endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Randomized bench for lock_entry_ctrl against a queue-based model of the entry rules.
module tb_lock_entry_ctrl;
    localparam int DEPTH    = 4;
    localparam int GAP      = 2;
    localparam int SETTLE   = 2;
    localparam int MAX_FAIL = 3;
    localparam int LOCKOUT  = 16;
    localparam int TIMEOUT  = 64;
    localparam int P        = 1 + GAP;

    logic       clk = 1'b0;
    logic       rst, dv, sub, prog, relock;
    logic [3:0] dig;
    logic [7:0] ack;
    logic       ce, setd, busy, unl, lko, ovf;
    logic [3:0] data;
    logic [2:0] fcnt;

    lock_entry_ctrl #(
        .DEPTH(DEPTH), .GAP_CYCLES(GAP), .SETTLE_CYCLES(SETTLE), .MAX_FAIL(MAX_FAIL),
        .LOCKOUT_CYCLES(LOCKOUT), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .i_Rst(rst), .i_digit_valid(dv), .iv_digit(dig), .i_submit(sub),
        .i_program(prog), .i_relock(relock), .iv_ack(ack), .o_CE(ce), .o_set_data(setd),
        .ov_data(data), .o_busy(busy), .o_unlocked(unl), .o_locked_out(lko),
        .o_overflow(ovf), .ov_fail_cnt(fcnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: buffered digits, consecutive failures, sticky overflow.
    int m_buf[$];
    int m_fail;
    bit m_ovf;

    int   obs_off[$];
    int   obs_dat[$];
    int   obs_set[$];
    logic b_chk;
    logic ovf_at1;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic m_push(input int d);
        if (m_buf.size() < DEPTH) m_buf.push_back(d);
        else m_ovf = 1'b1;
    endtask

    task automatic push_digit(input int d);
        dv = 1'b1; dig = 4'(d);
        tick;
        dv = 1'b0;
        m_push(d);
    endtask

    task automatic run_window(input int n);
        obs_off.delete(); obs_dat.delete(); obs_set.delete();
        for (int k = 1; k <= n; k++) begin
            tick;
            sub = 1'b0; prog = 1'b0; dv = 1'b0;
            if (k == 1) ovf_at1 = ovf;
            if (ce === 1'b1) begin
                obs_off.push_back(k); obs_dat.push_back(int'(data)); obs_set.push_back(int'(setd));
            end
        end
    endtask

    // Submits with the lock answering ok; ends one cycle after the expected check cycle.
    task automatic attempt(input bit ok);
        int w;
        w   = m_buf.size() * P + SETTLE + 1;
        ack = {ok, 7'($urandom)};
        sub = 1'b1;
        m_ovf = 1'b0;
        run_window(w);
        b_chk = busy;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; dv = 1'b0; dig = 4'd0; sub = 1'b0; prog = 1'b0; relock = 1'b0; ack = 8'd0;
        tick; tick;
        checks++; if ({ce, setd, busy, unl, lko, ovf} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b exp 000000", {ce, setd, busy, unl, lko, ovf}); end
        checks++; if (data !== 4'd0) begin errors++; $display("FAIL reset_data: got %0d exp 0", data); end
        checks++; if (fcnt !== 3'd0) begin errors++; $display("FAIL reset_fcnt: got %0d exp 0", fcnt); end
        rst = 1'b0;
        m_buf.delete(); m_fail = 0; m_ovf = 1'b0;
        tick;
    endtask

    task automatic test_unlock;
        for (int r = 0; r < 4; r++) begin
            int n;
            m_buf.delete();
            n = (r == 0) ? 4 : int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) push_digit((r == 0) ? i + 1 : int'($urandom_range(0, 15)));
            attempt(1'b1);
            checks++;
            if (obs_off.size() !== m_buf.size()) begin errors++; $display("FAIL unlock_npulse: got %0d exp %0d", obs_off.size(), m_buf.size()); end
            else foreach (m_buf[j]) begin
                checks++;
                if (obs_off[j] !== 1 + j * P || obs_dat[j] !== m_buf[j] || obs_set[j] !== 0) begin
                    errors++; $display("FAIL unlock_pulse%0d: got off %0d dat %0d set %0d exp off %0d dat %0d set 0", j, obs_off[j], obs_dat[j], obs_set[j], 1 + j * P, m_buf[j]);
                end
            end
            checks++; if (b_chk !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL unlock_chk_timing: got busy %b,%b exp 1,0", b_chk, busy); end
            checks++; if (unl !== 1'b1 || fcnt !== 3'd0) begin errors++; $display("FAIL unlock_state: got unl %b fcnt %0d exp 1 0", unl, fcnt); end
            m_fail = 0; m_buf.delete();
            relock = 1'b1; tick; relock = 1'b0;
            checks++; if (unl !== 1'b0) begin errors++; $display("FAIL relock: got unl %b exp 0", unl); end
        end
    endtask

    task automatic test_lockout;
        for (int a = 1; a <= MAX_FAIL; a++) begin
            int n;
            m_buf.delete();
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) push_digit(int'($urandom_range(0, 15)));
            attempt(1'b0);
            m_fail++;
            checks++; if (obs_off.size() !== m_buf.size()) begin errors++; $display("FAIL lock_npulse: got %0d exp %0d", obs_off.size(), m_buf.size()); end
            checks++; if (fcnt !== 3'(m_fail)) begin errors++; $display("FAIL lock_fcnt%0d: got %0d exp %0d", a, fcnt, m_fail); end
            checks++; if (lko !== (m_fail == MAX_FAIL)) begin errors++; $display("FAIL lock_lko%0d: got %b exp %b", a, lko, m_fail == MAX_FAIL); end
            m_buf.delete();
        end
        for (int c = 1; c < LOCKOUT; c++) begin
            dv = c[0]; dig = 4'($urandom_range(0, 15)); sub = 1'b1;
            tick;
            checks++; if (lko !== 1'b1 || ce !== 1'b0) begin errors++; $display("FAIL lockout_hold%0d: got lko %b ce %b exp 1 0", c, lko, ce); end
        end
        dv = 1'b0; sub = 1'b0;
        tick;
        m_fail = 0;
        checks++; if (lko !== 1'b0 || fcnt !== 3'd0) begin errors++; $display("FAIL lockout_exit: got lko %b fcnt %0d exp 0 0", lko, fcnt); end
        sub = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick; sub = 1'b0;
            checks++; if (ce !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lockout_buf_empty%0d: got ce %b busy %b exp 0 0", k, ce, busy); end
        end
    endtask

    task automatic test_overflow;
        m_buf.delete();
        for (int i = 0; i < DEPTH + 1; i++) push_digit(int'($urandom_range(0, 15)));
        checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL ovf_set: got %b exp %b", ovf, m_ovf); end
        attempt(1'b1);
        checks++; if (ovf_at1 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", ovf_at1); end
        checks++;
        if (obs_off.size() !== m_buf.size()) begin errors++; $display("FAIL ovf_npulse: got %0d exp %0d", obs_off.size(), m_buf.size()); end
        else foreach (m_buf[j]) begin
            checks++;
            if (obs_off[j] !== 1 + j * P || obs_dat[j] !== m_buf[j]) begin
                errors++; $display("FAIL ovf_pulse%0d: got off %0d dat %0d exp off %0d dat %0d", j, obs_off[j], obs_dat[j], 1 + j * P, m_buf[j]);
            end
        end
        m_buf.delete();
        relock = 1'b1; tick; relock = 1'b0;
    endtask

    task automatic test_program;
        m_buf.delete();
        push_digit(int'($urandom_range(0, 15)));
        attempt(1'b1);
        checks++; if (unl !== 1'b1) begin errors++; $display("FAIL prog_unlock: got %b exp 1", unl); end
        m_buf.delete();
        push_digit(9); push_digit(8); push_digit(7);
        sub = 1'b1; tick; sub = 1'b0; tick;
        checks++; if (ce !== 1'b0 || busy !== 1'b0 || unl !== 1'b1) begin errors++; $display("FAIL prog_submit_ignored: got ce %b busy %b unl %b exp 0 0 1", ce, busy, unl); end
        prog = 1'b1;
        run_window(m_buf.size() * P);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prog_last_gap: got busy %b exp 1", busy); end
        tick;
        checks++; if ({unl, busy, setd} !== 3'b000 || fcnt !== 3'd0) begin errors++; $display("FAIL prog_done: got unl/busy/set %b fcnt %0d exp 000 0", {unl, busy, setd}, fcnt); end
        checks++;
        if (obs_off.size() !== m_buf.size()) begin errors++; $display("FAIL prog_npulse: got %0d exp %0d", obs_off.size(), m_buf.size()); end
        else foreach (m_buf[j]) begin
            checks++;
            if (obs_off[j] !== 1 + j * P || obs_dat[j] !== m_buf[j] || obs_set[j] !== 1) begin
                errors++; $display("FAIL prog_pulse%0d: got off %0d dat %0d set %0d exp off %0d dat %0d set 1", j, obs_off[j], obs_dat[j], obs_set[j], 1 + j * P, m_buf[j]);
            end
        end
        m_buf.delete(); m_fail = 0;
        push_digit(5);
        prog = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick; prog = 1'b0;
            checks++; if (ce !== 1'b0) begin errors++; $display("FAIL prog_in_idle%0d: got ce %b exp 0", k, ce); end
        end
        rst = 1'b1; tick; rst = 1'b0;
        m_buf.delete(); m_fail = 0; m_ovf = 1'b0;
    endtask

    task automatic test_edge;
        sub = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick; sub = 1'b0;
            checks++; if (ce !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_submit%0d: got ce %b busy %b exp 0 0", k, ce, busy); end
        end
        m_buf.delete();
        push_digit(int'($urandom_range(0, 15))); push_digit(int'($urandom_range(0, 15)));
        dv = 1'b1; dig = 4'($urandom_range(0, 15));
        attempt(1'b1);
        checks++;
        if (obs_off.size() !== m_buf.size()) begin errors++; $display("FAIL simul_npulse: got %0d exp %0d", obs_off.size(), m_buf.size()); end
        else foreach (m_buf[j]) begin
            checks++;
            if (obs_dat[j] !== m_buf[j]) begin errors++; $display("FAIL simul_pulse%0d: got dat %0d exp %0d", j, obs_dat[j], m_buf[j]); end
        end
        m_buf.delete();
        relock = 1'b1; tick; relock = 1'b0;
        push_digit(int'($urandom_range(0, 15)));
        attempt(1'b0);
        m_fail = 1; m_buf.delete();
        checks++; if (fcnt !== 3'(m_fail)) begin errors++; $display("FAIL edge_fail: got %0d exp %0d", fcnt, m_fail); end
        for (int i = 0; i < 3; i++) push_digit(int'($urandom_range(0, 15)));
        sub = 1'b1; tick; sub = 1'b0;
        checks++; if (ce !== 1'b1) begin errors++; $display("FAIL edge_send: got ce %b exp 1", ce); end
        tick;
        checks++; if (ce !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL edge_gap: got ce %b busy %b exp 0 1", ce, busy); end
        rst = 1'b1; tick;
        checks++; if ({ce, setd, busy, unl, lko, ovf, data, fcnt} !== 13'd0) begin errors++; $display("FAIL rst_mid_gap: got %b exp all zero", {ce, setd, busy, unl, lko, ovf, data, fcnt}); end
        rst = 1'b0;
        m_buf.delete(); m_fail = 0; m_ovf = 1'b0;
        sub = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick; sub = 1'b0;
            checks++; if (ce !== 1'b0) begin errors++; $display("FAIL rst_buf_empty%0d: got ce %b exp 0", k, ce); end
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 10; r++) begin
            int n;
            bit ok;
            m_buf.delete();
            n  = int'($urandom_range(1, DEPTH));
            ok = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < n; i++) push_digit(int'($urandom_range(0, 15)));
            attempt(ok);
            if (ok) m_fail = 0;
            else m_fail++;
            checks++;
            if (obs_off.size() !== m_buf.size()) begin errors++; $display("FAIL rnd%0d_npulse: got %0d exp %0d", r, obs_off.size(), m_buf.size()); end
            else foreach (m_buf[j]) begin
                checks++;
                if (obs_off[j] !== 1 + j * P || obs_dat[j] !== m_buf[j]) begin
                    errors++; $display("FAIL rnd%0d_pulse%0d: got off %0d dat %0d exp off %0d dat %0d", r, j, obs_off[j], obs_dat[j], 1 + j * P, m_buf[j]);
                end
            end
            checks++;
            if (fcnt !== 3'(m_fail) || unl !== ok || lko !== (m_fail == MAX_FAIL)) begin
                errors++; $display("FAIL rnd%0d_state: got fcnt %0d unl %b lko %b exp %0d %b %b", r, fcnt, unl, lko, m_fail, ok, m_fail == MAX_FAIL);
            end
            m_buf.delete();
            if (ok) begin
                relock = 1'b1; tick; relock = 1'b0;
            end else if (m_fail == MAX_FAIL) begin
                repeat (LOCKOUT) tick;
                m_fail = 0;
                checks++; if (lko !== 1'b0 || fcnt !== 3'd0) begin errors++; $display("FAIL rnd%0d_lockout_exit: got lko %b fcnt %0d exp 0 0", r, lko, fcnt); end
            end
        end
    endtask

`ifdef LOCK_ENTRY_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        push_digit(int'($urandom_range(0, 15))); push_digit(int'($urandom_range(0, 15)));
        repeat (TIMEOUT + 6) tick;
        m_buf.delete();
        sub = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick; sub = 1'b0;
            checks++; if (ce !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout%0d: got ce %b busy %b exp 0 0", k, ce, busy); end
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_unlock;
        test_lockout;
        test_overflow;
        test_program;
        test_edge;
        test_random;
`ifdef LOCK_ENTRY_CTRL_TIMEOUT_EN
        test_timeout;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
